// File: rtl/win_scan_pkg.sv
// rtl/win_scan_pkg.sv - shared state encodings and helpers for the window scan sequencer
package win_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int WIN_DEFAULT = 17;
    localparam int WIN_HALF    = (WIN_DEFAULT - 1) / 2;

    // Never returns less than 1 so a degenerate dimension still yields a legal vector width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/win_scan_counter.sv
// rtl/win_scan_counter.sv - raster row/column counter pair with position flags
module win_scan_counter
    import win_scan_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 17,
    parameter int CW    = clog2(IMG_W),
    parameter int RW    = clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          row_eq_max,
    output logic          col_eq_max,
    output logic          col_ge_threshold
);

    assign row_eq_max       = (row == RW'(IMG_H - 1));
    assign col_eq_max       = (col == CW'(IMG_W - 1));
    assign col_ge_threshold = (col >= CW'(WIN - 1));

    // The row saturates on the last line so the final wrap leaves it at IMG_H-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_eq_max) begin
                col <= '0;
                if (!row_eq_max) begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_scan_sequencer.sv
// rtl/window_scan_sequencer.sv - raster scan FSM for a sliding window; WIN_SCAN_STALL_CNT_EN adds stall_cnt
module window_scan_sequencer
    import win_scan_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 17,
    parameter int CW    = clog2(IMG_W),
    parameter int RW    = clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          shift_en,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          row_eq_max,
    output logic          col_eq_max,
    output logic          col_ge_threshold,
    output logic          busy,
    output logic          frame_done
`ifdef WIN_SCAN_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          beat;
    logic          scanning;
    logic          start_ok;

    assign scanning = (state == ST_FILL) || (state == ST_RUN);
    assign start_ok = (state == ST_IDLE) && start && !abort;
    // abort gates in_ready so an abandoned frame never takes a final pixel.
    assign in_ready = scanning && out_ready && !abort;
    assign beat     = in_valid && in_ready;
    assign shift_en = beat;
    assign busy     = (state != ST_IDLE);

    win_scan_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .WIN  (WIN),
        .CW   (CW),
        .RW   (RW)
    ) u_counter (
        .clk             (clk),
        .rst             (rst),
        .clr             (abort || start_ok),
        .en              (beat),
        .row             (row),
        .col             (col),
        .row_eq_max      (row_eq_max),
        .col_eq_max      (col_eq_max),
        .col_ge_threshold(col_ge_threshold)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        if (beat && row == RW'(WIN - 2) && col_eq_max) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (beat) begin
                            if (col_ge_threshold) begin
                                win_valid <= 1'b1;
                                win_row   <= row - RW'(WIN - 1);
                                win_col   <= col - CW'(WIN - 1);
                            end
                            if (row_eq_max && col_eq_max) begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        frame_done <= 1'b1;
                        state      <= ST_DONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef WIN_SCAN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cnt <= '0;
        end else if (scanning && in_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_scan_sequencer.sv
// tb/tb_window_scan_sequencer.sv - directed self-checking bench for window_scan_sequencer
module tb_window_scan_sequencer;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WIN   = 3;
    localparam int CW    = 3;
    localparam int RW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_ready = 1'b0;
    logic          shift_en;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          row_eq_max;
    logic          col_eq_max;
    logic          col_ge_threshold;
    logic          busy;
    logic          frame_done;
`ifdef WIN_SCAN_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats, wv_cnt, fd_cnt, last_beat_cyc, fd_cyc;
    int first_r, first_c, last_r, last_c;
    int wv_saved;

    always #5 clk = ~clk;

    window_scan_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .CW(CW), .RW(RW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_ready       (out_ready),
        .shift_en        (shift_en),
        .win_valid       (win_valid),
        .win_row         (win_row),
        .win_col         (win_col),
        .row_eq_max      (row_eq_max),
        .col_eq_max      (col_eq_max),
        .col_ge_threshold(col_ge_threshold),
        .busy            (busy),
        .frame_done      (frame_done)
`ifdef WIN_SCAN_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        beats = 0; wv_cnt = 0; fd_cnt = 0; last_beat_cyc = -1; fd_cyc = -1;
        first_r = -1; first_c = -1; last_r = -1; last_c = -1;
    endtask

    // Handshake sampled mid-cycle, registered outputs 1 time unit after the edge.
    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) begin
            beats++;
            last_beat_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (win_valid) begin
            if (wv_cnt == 0) begin
                first_r = int'(win_row);
                first_c = int'(win_col);
            end
            last_r = int'(win_row);
            last_c = int'(win_col);
            wv_cnt++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    endtask

    task automatic start_frame();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_beats(input int target);
        int n;
        n = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (beats < target && n < 400) begin
            tick();
            n++;
        end
        check("beats_reached", beats, target);
    endtask

    task automatic run_frame(input string tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (fd_cnt == 0 && n < 400) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_done_seen"}, fd_cnt, 1);
    endtask

    initial begin
        clear_stats();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_win_row", win_row, 0);
        check("rst_win_col", win_col, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_shift_en", shift_en, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);

        // 1: full frame back to back
        clear_stats();
        start_frame();
        check("t1_busy_after_start", busy, 1);
        run_frame("t1");
        check("t1_beats", beats, 48);
        check("t1_windows", wv_cnt, 24);
        check("t1_first_row", first_r, 0);
        check("t1_first_col", first_c, 0);
        check("t1_last_row", last_r, 3);
        check("t1_last_col", last_c, 5);
        check("t1_done_latency", fd_cyc - last_beat_cyc, 2);
        check("t1_busy_in_done", busy, 1);
        tick();
        check("t1_busy_low", busy, 0);
        check("t1_done_pulse", frame_done, 0);
        check("t1_row_eq_max_end", row_eq_max, 1);
        check("t1_col_eq_max_end", col_eq_max, 0);

        // 2: backpressure mid-row 3
        clear_stats();
        start_frame();
        check("t2_row_cleared", row_eq_max, 0);
        run_to_beats(27);
        wv_saved = wv_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_stall_in_ready", in_ready, 0);
            check("t2_stall_col_ge", col_ge_threshold, 1);
            tick();
        end
        check("t2_stall_beats", beats, 27);
        check("t2_stall_windows", wv_cnt, wv_saved);
        run_frame("t2");
        check("t2_windows", wv_cnt, 24);
        tick();

        // 3: abort at beat 20, then a clean frame
        clear_stats();
        start_frame();
        run_to_beats(20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check("t3_abort_busy", busy, 0);
        check("t3_abort_win_valid", win_valid, 0);
        check("t3_abort_col_ge", col_ge_threshold, 0);
        repeat (4) tick();
        check("t3_abort_no_done", fd_cnt, 0);
        clear_stats();
        start_frame();
        run_frame("t3");
        check("t3_windows", wv_cnt, 24);
        tick();

        // 4: start pulsed during RUN is ignored
        clear_stats();
        start_frame();
        run_to_beats(20);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        run_frame("t4");
        check("t4_windows", wv_cnt, 24);
        repeat (3) tick();
        check("t4_single_done", fd_cnt, 1);
        check("t4_idle_after", busy, 0);

        // 5: rst mid-frame
        clear_stats();
        start_frame();
        run_to_beats(30);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_win_valid", win_valid, 0);
        check("t5_win_row", win_row, 0);
        check("t5_win_col", win_col, 0);
        check("t5_frame_done", frame_done, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 0);
        check("t5_col_ge", col_ge_threshold, 0);
        rst = 1'b0;
        tick();

`ifdef WIN_SCAN_STALL_CNT_EN
        // 6: stall counter in FILL
        start_frame();
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (7) tick();
        check("t6_stall_cnt", stall_cnt, 7);
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start_frame();
        check("t6_stall_cleared", stall_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
